// File: rtl/biquad_seq_ctrl_pkg.sv
// Shared codes for the biquad MAC sequencer: FSM state encodings and the
// datapath mux select values for coefficient (S), state (C) and addend (Z).
package biquad_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_S5   = 3'd5,
        ST_UPD  = 3'd6
    } state_t;

    localparam logic [2:0] SEL_S_ZERO = 3'b000;
    localparam logic [2:0] SEL_S_A1   = 3'b001;
    localparam logic [2:0] SEL_S_A2   = 3'b010;
    localparam logic [2:0] SEL_S_B0   = 3'b011;
    localparam logic [2:0] SEL_S_B1   = 3'b100;
    localparam logic [2:0] SEL_S_B2   = 3'b101;

    localparam logic [1:0] SEL_C_ZERO = 2'b00;
    localparam logic [1:0] SEL_C_FK1  = 2'b01;
    localparam logic [1:0] SEL_C_FK2  = 2'b10;
    localparam logic [1:0] SEL_C_FK   = 2'b11;

    // Addend code 010 (yk) is never fed back by this schedule.
    localparam logic [2:0] SEL_Z_ZERO  = 3'b000;
    localparam logic [2:0] SEL_Z_UK    = 3'b001;
    localparam logic [2:0] SEL_Z_ACUM1 = 3'b011;
    localparam logic [2:0] SEL_Z_ACUM2 = 3'b100;
    localparam logic [2:0] SEL_Z_ACUM3 = 3'b101;

    typedef struct packed {
        logic [2:0] sel_s;
        logic [1:0] sel_c;
        logic [2:0] sel_z;
    } sel_t;

    function automatic sel_t step_sel(input state_t st);
        sel_t sel;
        sel = '{SEL_S_ZERO, SEL_C_ZERO, SEL_Z_ZERO};
        case (st)
            ST_S1:   sel = '{SEL_S_A1, SEL_C_FK1, SEL_Z_UK};
            ST_S2:   sel = '{SEL_S_A2, SEL_C_FK2, SEL_Z_ACUM1};
            ST_S3:   sel = '{SEL_S_B0, SEL_C_FK,  SEL_Z_ZERO};
            ST_S4:   sel = '{SEL_S_B1, SEL_C_FK1, SEL_Z_ACUM2};
            ST_S5:   sel = '{SEL_S_B2, SEL_C_FK2, SEL_Z_ACUM3};
            default: sel = '{SEL_S_ZERO, SEL_C_ZERO, SEL_Z_ZERO};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/biquad_seq_ctrl_mac_step_timer.sv
// Per-step cycle counter: flags the final cycle of a MAC step so the
// sequencer knows when the multiplier/adder result may be loaded.
module mac_step_timer #(
    parameter int MAC_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic last_cycle
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 4'd0;
        end else begin
            count <= count + 4'd1;
        end
    end

    assign last_cycle = (count == 4'(MAC_LAT - 1));

endmodule

// File: rtl/biquad_seq_ctrl.sv
// Biquad MAC sequencer: walks the datapath through the five multiply-accumulate
// steps per sample tick, then shifts the filter state and reports done.
module biquad_seq_ctrl
    import biquad_seq_ctrl_pkg::*;
#(
    parameter int MAC_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       clr_ovr,
    output logic [2:0] controlS,
    output logic [1:0] controlC,
    output logic [2:0] controlZ,
    output logic       en_acum1,
    output logic       en_fk,
    output logic       en_acum2,
    output logic       en_acum3,
    output logic       en_yk,
    output logic       en_shift,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    state_t state;
    logic   last_cycle;
    logic   advance;
    logic   clear;
    sel_t   sel;

    // Any state change (and all of IDLE) restarts the step timer from zero.
    always_comb begin
        advance = 1'b1;
        case (state)
            ST_IDLE: advance = sample_tick;
            ST_S1, ST_S2, ST_S3, ST_S4, ST_S5: advance = last_cycle;
            ST_UPD:  advance = 1'b1;
            default: advance = 1'b1;
        endcase
    end

    assign clear = advance || (state == ST_IDLE);

    mac_step_timer #(
        .MAC_LAT(MAC_LAT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .last_cycle(last_cycle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            overrun <= 1'b0;
        end else begin
            if (advance) begin
                case (state)
                    ST_IDLE: state <= ST_S1;
                    ST_S1:   state <= ST_S2;
                    ST_S2:   state <= ST_S3;
                    ST_S3:   state <= ST_S4;
                    ST_S4:   state <= ST_S5;
                    ST_S5:   state <= ST_UPD;
                    default: state <= ST_IDLE;
                endcase
            end
            // A fresh overrun event takes priority over a simultaneous clear.
            if (sample_tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        sel      = step_sel(state);
        controlS = sel.sel_s;
        controlC = sel.sel_c;
        controlZ = sel.sel_z;
        en_acum1 = (state == ST_S1) && last_cycle;
        en_fk    = (state == ST_S2) && last_cycle;
        en_acum2 = (state == ST_S3) && last_cycle;
        en_acum3 = (state == ST_S4) && last_cycle;
        en_yk    = (state == ST_S5) && last_cycle;
        en_shift = (state == ST_UPD);
        done     = (state == ST_UPD);
        busy     = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_biquad_seq_ctrl.sv
// Self-checking bench: two sequencers (MAC_LAT 1 and 3) share stimulus and are
// compared every cycle against an offset-based model plus literal spot checks.
module tb_biquad_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_tick = 1'b0;
    logic clr_ovr = 1'b0;

    logic [2:0] ctl_s_1, ctl_s_3;
    logic [1:0] ctl_c_1, ctl_c_3;
    logic [2:0] ctl_z_1, ctl_z_3;
    logic [4:0] en_step_1, en_step_3;
    logic en_shift_1, en_shift_3, busy_1, busy_3, done_1, done_3, overrun_1, overrun_3;

    logic [7:0]  sel_1, sel_3;
    logic [16:0] act_1, act_3;

    int checkCount = 0;
    int errorCount = 0;

    localparam int LAT [2] = '{1, 3};
    localparam int SEL_S [5] = '{1, 2, 3, 4, 5};
    localparam int SEL_C [5] = '{1, 2, 3, 1, 2};
    localparam int SEL_Z [5] = '{1, 3, 0, 4, 5};

    bit mBusy [2];
    int mK [2];
    bit mOvr [2];

    always #5 clk = ~clk;

    biquad_seq_ctrl #(.MAC_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .clr_ovr(clr_ovr),
        .controlS(ctl_s_1), .controlC(ctl_c_1), .controlZ(ctl_z_1),
        .en_acum1(en_step_1[4]), .en_fk(en_step_1[3]), .en_acum2(en_step_1[2]),
        .en_acum3(en_step_1[1]), .en_yk(en_step_1[0]), .en_shift(en_shift_1),
        .busy(busy_1), .done(done_1), .overrun(overrun_1)
    );

    biquad_seq_ctrl #(.MAC_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .clr_ovr(clr_ovr),
        .controlS(ctl_s_3), .controlC(ctl_c_3), .controlZ(ctl_z_3),
        .en_acum1(en_step_3[4]), .en_fk(en_step_3[3]), .en_acum2(en_step_3[2]),
        .en_acum3(en_step_3[1]), .en_yk(en_step_3[0]), .en_shift(en_shift_3),
        .busy(busy_3), .done(done_3), .overrun(overrun_3)
    );

    assign sel_1 = {ctl_s_1, ctl_c_1, ctl_z_1};
    assign sel_3 = {ctl_s_3, ctl_c_3, ctl_z_3};
    assign act_1 = {sel_1, en_step_1, en_shift_1, busy_1, done_1, overrun_1};
    assign act_3 = {sel_3, en_step_3, en_shift_3, busy_3, done_3, overrun_3};

    // Expected outputs from the cycle offset k since S1 began (k = 5*L is UPD).
    function automatic logic [16:0] modelOut(input bit b, input int k, input int l, input bit ovr);
        logic [2:0] s;
        logic [1:0] c;
        logic [2:0] z;
        logic [4:0] en;
        logic sh;
        int st;
        s = 3'd0; c = 2'd0; z = 3'd0; en = 5'd0; sh = 1'b0;
        if (b) begin
            if (k < 5 * l) begin
                st = k / l;
                s = 3'(SEL_S[st]);
                c = 2'(SEL_C[st]);
                z = 3'(SEL_Z[st]);
                if ((k % l) == l - 1) en = 5'b10000 >> st;
            end else begin
                sh = 1'b1;
            end
        end
        return {s, c, z, en, sh, b, sh, ovr};
    endfunction

    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            bit setOvr;
            setOvr = sample_tick && mBusy[i];
            if (reset) begin
                mBusy[i] = 1'b0;
                mK[i] = 0;
                mOvr[i] = 1'b0;
            end else begin
                if (mBusy[i]) begin
                    mK[i] = mK[i] + 1;
                    if (mK[i] > 5 * LAT[i]) mBusy[i] = 1'b0;
                end else if (sample_tick) begin
                    mBusy[i] = 1'b1;
                    mK[i] = 0;
                end
                if (setOvr) mOvr[i] = 1'b1;
                else if (clr_ovr) mOvr[i] = 1'b0;
            end
        end
    endtask

    task automatic compareModel();
        logic [16:0] exp1, exp3;
        exp1 = modelOut(mBusy[0], mK[0], LAT[0], mOvr[0]);
        exp3 = modelOut(mBusy[1], mK[1], LAT[1], mOvr[1]);
        checkCount++;
        if (act_1 !== exp1) begin
            errorCount++;
            $display("[TB] FAIL model_lat1 t=%0t: got %b want %b", $time, act_1, exp1);
        end
        checkCount++;
        if (act_3 !== exp3) begin
            errorCount++;
            $display("[TB] FAIL model_lat3 t=%0t: got %b want %b", $time, act_3, exp3);
        end
    endtask

    // Each call checks the cycle just clocked, then drives inputs for the current cycle.
    task automatic applyStimulus(input logic r, input logic t, input logic c);
        @(posedge clk);
        modelStep();
        #1;
        compareModel();
        @(negedge clk);
        reset = r;
        sample_tick = t;
        clr_ovr = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held, with a tick during reset that must be discarded.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_all_lat1", 32'(act_1), 32'd0);
        checkOutput("reset_all_lat3", 32'(act_3), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_tick_ignored", 32'(busy_1), 32'd0);

        // Nominal sequence on both latencies from one tick.
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            case (k)
                1: begin
                    checkOutput("l1_s1_sel", 32'(sel_1), 32'(8'b001_01_001));
                    checkOutput("l1_s1_en", 32'(en_step_1), 32'(5'b10000));
                    checkOutput("l3_s1_en_early", 32'(en_step_3), 32'd0);
                end
                2: checkOutput("l1_s2_sel", 32'(sel_1), 32'(8'b010_10_011));
                3: begin
                    checkOutput("l1_s3_sel", 32'(sel_1), 32'(8'b011_11_000));
                    checkOutput("l3_s1_en", 32'(en_step_3), 32'(5'b10000));
                    checkOutput("l3_s1_held", 32'(sel_3), 32'(8'b001_01_001));
                end
                4: checkOutput("l1_s4_en", 32'(en_step_1), 32'(5'b00010));
                5: checkOutput("l1_s5_sel", 32'(sel_1), 32'(8'b101_10_101));
                6: begin
                    checkOutput("l1_upd", 32'({en_shift_1, done_1, sel_1}), 32'(10'b11_00000000));
                    checkOutput("l3_s2_en", 32'(en_step_3), 32'(5'b01000));
                end
                7:  checkOutput("l1_idle", 32'(busy_1), 32'd0);
                12: checkOutput("l3_s4_en", 32'(en_step_3), 32'(5'b00010));
                15: checkOutput("l3_s5_en", 32'(en_step_3), 32'(5'b00001));
                16: checkOutput("l3_done", 32'(done_3), 32'd1);
                17: checkOutput("l3_idle", 32'(busy_3), 32'd0);
                default: ;
            endcase
        end

        // Tick while busy: ignored but sets overrun.
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ovr_set", 32'(overrun_1), 32'd1);
        checkOutput("ovr_seq_kept", 32'(sel_1), 32'(8'b101_10_101));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ovr_done", 32'(done_1), 32'd1);
        idle(20);

        // Clear and set in the same cycle: set wins; then clear alone.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ovr_set_wins", 32'(overrun_1), 32'd1);
        idle(10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ovr_clr_lat1", 32'(overrun_1), 32'd0);
        checkOutput("ovr_clr_lat3", 32'(overrun_3), 32'd0);
        idle(20);

        // Reset during S3 aborts without a state shift.
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rst_s3_en", 32'(en_step_1), 32'(5'b00100));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_abort", 32'({busy_1, en_step_1, en_shift_1}), 32'd0);
        checkOutput("rst_abort_lat3", 32'(busy_3), 32'd0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(6);
        checkOutput("rst_rerun_done", 32'(done_1), 32'd1);
        idle(20);

        // Back-to-back at the minimum period for MAC_LAT=1.
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(6);
        checkOutput("b2b_done1", 32'(done_1), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("b2b_idle_at_tick", 32'(busy_1), 32'd0);
        idle(6);
        checkOutput("b2b_done2", 32'(done_1), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b2b_no_ovr", 32'(overrun_1), 32'd0);
        idle(20);

        // Tick in UPD is still a busy tick.
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("upd_done", 32'(done_1), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("upd_tick_ignored", 32'({busy_1, overrun_1}), 32'(2'b01));
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
